glitch_filter: RTL

GLITCH_FILTER -- requirements
Module: glitch_filter

---
 rtl/glitch_filter_pkg.sv | 20 ++
 rtl/glitch_filter_sync_chain.sv | 30 +++
 rtl/glitch_filter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/glitch_filter_pkg.sv
// glitch_filter_pkg: shared types and default parameters for glitch_filter.
//   stateT              - 2-bit qualification FSM state
//   DEFAULT_STAGES      - default synchroniser depth
//   DEFAULT_FILTER_LEN  - default number of stable samples needed to change q
//   DEFAULT_CNT_W       - default stability counter width
package glitch_filter_pkg;

    // Gray-style encoding: q is simply state[1], and each legal move flips one bit.
    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        PEND_HIGH = 2'b01,
        ST_HIGH   = 2'b11,
        PEND_LOW  = 2'b10
    } stateT;

    localparam int unsigned DEFAULT_STAGES     = 2;
    localparam int unsigned DEFAULT_FILTER_LEN = 4;
    localparam int unsigned DEFAULT_CNT_W      = 4;

endpackage

// File: rtl/glitch_filter_sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings the asynchronous level d into
// the c domain.
//   c    - clock, rising edge
//   rstn - synchronous active-low reset, clears every stage
//   d    - asynchronous input level
//   s    - synchronised level (last stage)
module sync_chain
    import glitch_filter_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic c,
    input  logic rstn,
    input  logic d,
    output logic s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge c) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign s = chain[STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// glitch_filter: synchronises a raw level and only passes a change to q once
// the synchronised level has been stable for FILTER_LEN consecutive samples.
//   c     - clock, rising edge
//   rstn  - synchronous active-low reset
//   d     - asynchronous, possibly glitchy input level
//   q     - filtered, registered level
//   busy  - a level change is pending qualification
//   rise  - one-cycle pulse in the first cycle q reads 1 (GLITCH_FILTER_EDGE_EN only)
//   fall  - one-cycle pulse in the first cycle q reads 0 (GLITCH_FILTER_EDGE_EN only)
// Build option: define GLITCH_FILTER_EDGE_EN to add the rise/fall edge outputs.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int unsigned STAGES     = DEFAULT_STAGES,
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
    input  logic c,
    input  logic rstn,
    input  logic d,
    output logic q,
`ifdef GLITCH_FILTER_EDGE_EN
    output logic rise,
    output logic fall,
`endif
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             s;
    stateT            state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES (STAGES)
    ) uSync (
        .c    (c),
        .rstn (rstn),
        .d    (d),
        .s    (s)
    );

    always_ff @(posedge c) begin
        if (!rstn) begin
            state <= ST_LOW;
            cnt   <= '0;
            q     <= 1'b0;
`ifdef GLITCH_FILTER_EDGE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
        end else begin
`ifdef GLITCH_FILTER_EDGE_EN
            rise <= 1'b0;
            fall <= 1'b0;
`endif
            case (state)
                ST_LOW: begin
                    q <= 1'b0;
                    if (s) begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PEND_HIGH: begin
                    if (!s) begin
                        // Glitch shorter than FILTER_LEN: drop it.
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        q     <= 1'b1;
`ifdef GLITCH_FILTER_EDGE_EN
                        rise  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    q <= 1'b1;
                    if (!s) begin
                        state <= PEND_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PEND_LOW: begin
                    if (s) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                        q     <= 1'b0;
`ifdef GLITCH_FILTER_EDGE_EN
                        fall  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Upset state register: fall back to a quiet low level.
                    state <= ST_LOW;
                    cnt   <= '0;
                    q     <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == PEND_HIGH) || (state == PEND_LOW);

endmodule
